// File: rtl/wb_rr_arbiter.sv
// Three-master Wishbone round-robin arbiter in front of a single shared slave.
// Define WB_ARB_TIMEOUT_EN to build in the stalled-strobe watchdog and its ABORT path.
module wb_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WB_ADDR_W      = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [2:0]             m_wb_cyc,
    input  logic [2:0]             m_wb_stb,
    input  logic [2:0]             m_wb_we,
    input  logic [3*WB_ADDR_W-1:0] m_wb_adr,
    input  logic [47:0]            m_wb_o_dat,
    input  logic [5:0]             m_wb_sel,
    input  logic [2:0]             m_wb_4_burst,
    input  logic [2:0]             m_wb_8_burst,
    output logic [2:0]             m_wb_ack,
    output logic [2:0]             m_wb_err,
    output logic [15:0]            m_wb_i_dat,
    output logic                   s_wb_cyc,
    output logic                   s_wb_stb,
    output logic                   s_wb_we,
    output logic                   s_wb_4_burst,
    output logic                   s_wb_8_burst,
    output logic [WB_ADDR_W-1:0]   s_wb_adr,
    output logic [15:0]            s_wb_o_dat,
    output logic [1:0]             s_wb_sel,
    input  logic [15:0]            s_wb_i_dat,
    input  logic                   s_wb_ack,
    input  logic                   s_wb_err,
    output logic [2:0]             o_grant
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

    state_t     state, state_nxt;
    logic [2:0] grant, grant_nxt;
    logic [1:0] rr_ptr, rr_ptr_nxt;
    logic [1:0] pick;
    logic       abort_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            grant  <= 3'b000;
            rr_ptr <= 2'd0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Walk from lowest to highest priority so the requester at rr_ptr wins last.
    always_comb begin
        pick = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (m_wb_cyc[(int'(rr_ptr) + k) % 3])
                pick = 2'((int'(rr_ptr) + k) % 3);
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt;
    logic       stall;

    // s_wb_stb is only ever nonzero in OWN, so this already implies ownership.
    assign stall     = s_wb_stb && !s_wb_ack && !s_wb_err;
    assign abort_req = stall && (to_cnt == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            to_cnt <= 8'd0;
        else
            to_cnt <= stall ? to_cnt + 8'd1 : 8'd0;
    end
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (|m_wb_cyc) begin
                    state_nxt  = OWN;
                    grant_nxt  = 3'b001 << pick;
                    rr_ptr_nxt = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                end
            end
            OWN: begin
                if (!(|(m_wb_cyc & grant))) begin
                    state_nxt = IDLE;
                    grant_nxt = 3'b000;
                end else if (abort_req) begin
                    state_nxt = ABORT;
                end
            end
            ABORT: begin
                state_nxt = IDLE;
                grant_nxt = 3'b000;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 3'b000;
            end
        endcase
    end

    // One-hot grant drives an AND-OR mux; everything toward the slave is zero unless owned.
    always_comb begin
        s_wb_cyc     = 1'b0;
        s_wb_stb     = 1'b0;
        s_wb_we      = 1'b0;
        s_wb_4_burst = 1'b0;
        s_wb_8_burst = 1'b0;
        s_wb_adr     = '0;
        s_wb_o_dat   = 16'h0000;
        s_wb_sel     = 2'b00;
        m_wb_ack     = 3'b000;
        m_wb_err     = 3'b000;
        if (state == OWN) begin
            for (int m = 0; m < 3; m++) begin
                if (grant[m]) begin
                    s_wb_cyc     = m_wb_cyc[m];
                    s_wb_stb     = m_wb_stb[m];
                    s_wb_we      = m_wb_we[m];
                    s_wb_4_burst = m_wb_4_burst[m];
                    s_wb_8_burst = m_wb_8_burst[m];
                    s_wb_adr     = m_wb_adr[m*WB_ADDR_W +: WB_ADDR_W];
                    s_wb_o_dat   = m_wb_o_dat[m*16 +: 16];
                    s_wb_sel     = m_wb_sel[m*2 +: 2];
                    m_wb_ack[m]  = s_wb_ack;
                    m_wb_err[m]  = s_wb_err;
                end
            end
        end else if (state == ABORT) begin
            m_wb_err = grant;
        end
    end

    assign m_wb_i_dat = s_wb_i_dat;
    assign o_grant    = grant;

endmodule
